// File: rtl/demux_pkg.sv
// Shared constants for the 1-to-4 stream demultiplexer: lane count,
// select width and per-lane delivered-word counter width.
package demux_pkg;

    localparam int LANES = 4;
    localparam int SEL_W = 2;
    localparam int CNT_W = 8;

endpackage

// File: rtl/demux_slot.sv
// One output lane: a single-entry holding register with a full flag and a
// wrapping count of words delivered to the lane consumer.
module demux_slot
    import demux_pkg::*;
#(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [W-1:0]     din,
    input  logic             ready,
    output logic             full,
    output logic [W-1:0]     dout,
    output logic [CNT_W-1:0] cnt
);

    logic drain;

    assign drain = full & ready;

    // A load wins over a drain in the same cycle so the lane streams at one
    // word per cycle; dout keeps its last word after a drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            full <= 1'b0;
            dout <= '0;
            cnt  <= '0;
        end else begin
            if (load) begin
                full <= 1'b1;
                dout <= din;
            end else if (drain) begin
                full <= 1'b0;
            end
            if (drain) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/demux1_4_stream.sv
// 1-to-4 valid/ready demultiplexer: each input word is routed to the lane
// named by in_sel and held there until that lane's consumer takes it.
module demux1_4_stream
    import demux_pkg::*;
#(
    parameter int W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [W-1:0]           in_data,
    input  logic [SEL_W-1:0]       in_sel,
    output logic [LANES-1:0]       out_valid,
    input  logic [LANES-1:0]       out_ready,
    output logic [LANES*W-1:0]     out_data,
    output logic [LANES*CNT_W-1:0] out_cnt,
    output logic                   busy
);

    logic [LANES-1:0] full;
    logic [LANES-1:0] load;
    logic             accept;

    // Handshakes: a word moves when valid & ready are both high at a rising
    // edge; ready never depends on valid, and valid never waits for ready.
    assign in_ready  = ~full[in_sel] | out_ready[in_sel];
    assign accept    = in_valid & in_ready;
    assign out_valid = full;
    assign busy      = |full;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign load[k] = accept && (in_sel == SEL_W'(k));

        demux_slot #(.W(W)) u_slot (
            .clk   (clk),
            .rst   (rst),
            .load  (load[k]),
            .din   (in_data),
            .ready (out_ready[k]),
            .full  (full[k]),
            .dout  (out_data[k*W +: W]),
            .cnt   (out_cnt[k*CNT_W +: CNT_W])
        );
    end

endmodule
